// File: rtl/monkey_table_if.sv
// monkey_table_if: request, random-read and scan bus of the placed-monkey table.
// The slave modport is the table, the master modport is the placement/draw side.
interface monkey_table_if #(
  parameter int DEPTH = 8,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int TW    = 2
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // add request and response
  logic          Add;
  logic [XW-1:0] Add_X;
  logic [YW-1:0] Add_Y;
  logic [TW-1:0] Add_Type;
  logic          Add_Ack;
  logic          Add_Err;
  logic [IW-1:0] Add_Idx;

  // delete and move
  logic          Del;
  logic [IW-1:0] Del_Idx;
  logic          Wr;
  logic [IW-1:0] Wr_Idx;
  logic [XW-1:0] Wr_X;
  logic [YW-1:0] Wr_Y;

  // random read
  logic [IW-1:0] Rd_Idx;
  logic          Rd_Valid;
  logic [XW-1:0] Rd_X;
  logic [YW-1:0] Rd_Y;
  logic [TW-1:0] Rd_Type;

  // scan stream
  logic          Scan_Start;
  logic          Scan_Ready;
  logic          Scan_Busy;
  logic          Scan_Vld;
  logic [IW-1:0] Scan_Idx;
  logic [XW-1:0] Scan_X;
  logic [YW-1:0] Scan_Y;
  logic [TW-1:0] Scan_Type;
  logic          Scan_Done;

  // occupancy
  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;

  modport slave (
    input  Add, Add_X, Add_Y, Add_Type, Del, Del_Idx, Wr, Wr_Idx, Wr_X, Wr_Y,
           Rd_Idx, Scan_Start, Scan_Ready,
    output Add_Ack, Add_Err, Add_Idx, Rd_Valid, Rd_X, Rd_Y, Rd_Type,
           Scan_Busy, Scan_Vld, Scan_Idx, Scan_X, Scan_Y, Scan_Type, Scan_Done,
           Count, Full, Empty
  );

  modport master (
    output Add, Add_X, Add_Y, Add_Type, Del, Del_Idx, Wr, Wr_Idx, Wr_X, Wr_Y,
           Rd_Idx, Scan_Start, Scan_Ready,
    input  Add_Ack, Add_Err, Add_Idx, Rd_Valid, Rd_X, Rd_Y, Rd_Type,
           Scan_Busy, Scan_Vld, Scan_Idx, Scan_X, Scan_Y, Scan_Type, Scan_Done,
           Count, Full, Empty
  );
endinterface

// File: rtl/monkey_table.sv
// monkey_table: slot store for placed monkeys (X/Y/type + valid bit).
// Lowest-free-slot allocation, delete, in-place move, combinational
// random read and a ready/valid scan engine that walks every slot.
module monkey_table #(
  parameter int DEPTH = 8,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int TW    = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  monkey_table_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW:0]   DEPTH_W  = (IW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  // Slot storage: kept in flops because the read port is combinational.
  logic          valid_q [DEPTH];
  logic [XW-1:0] x_q     [DEPTH];
  logic [YW-1:0] y_q     [DEPTH];
  logic [TW-1:0] type_q  [DEPTH];

  logic [CW-1:0] count_q, count_d;

  logic          add_ack_q, add_err_q;
  logic [IW-1:0] add_idx_q;

  scan_state_t   state_q;
  logic [IW-1:0] ptr_q;
  logic          scan_busy_q, scan_vld_q, scan_done_q;
  logic [IW-1:0] scan_idx_q;
  logic [XW-1:0] scan_x_q;
  logic [YW-1:0] scan_y_q;
  logic [TW-1:0] scan_type_q;

  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          add_ok, del_ok, wr_ok;
  logic [DEPTH-1:0] add_hit, del_hit, wr_hit;

  logic          rd_valid;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [TW-1:0] rd_type;

  // Guards non-power-of-two depths against indices past the last slot.
  function automatic logic in_range(input logic [IW-1:0] idx);
    return ({1'b0, idx} < DEPTH_W);
  endfunction

  // Lowest invalid slot as of the current state; a slot deleted this cycle
  // is still valid here, so it can never be handed out by the same edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign add_ok = bus.Add && free_found;
  assign del_ok = bus.Del && in_range(bus.Del_Idx) && valid_q[bus.Del_Idx];
  // A delete on the same slot beats a move.
  assign wr_ok  = bus.Wr && in_range(bus.Wr_Idx) && valid_q[bus.Wr_Idx] &&
                  !(bus.Del && (bus.Del_Idx == bus.Wr_Idx));

  // Per-slot strobes; add targets an invalid slot, del/wr target valid ones,
  // so at most one strobe is ever active per slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign add_hit[gi] = add_ok && (free_idx == IW'(gi));
    assign del_hit[gi] = del_ok && (bus.Del_Idx == IW'(gi));
    assign wr_hit[gi]  = wr_ok  && (bus.Wr_Idx  == IW'(gi));
  end

  // Slot update: add writes the whole record, del drops only the valid bit,
  // move rewrites position and keeps the tower type.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        type_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (add_hit[i]) begin
          valid_q[i] <= 1'b1;
          x_q[i]     <= bus.Add_X;
          y_q[i]     <= bus.Add_Y;
          type_q[i]  <= bus.Add_Type;
        end else if (del_hit[i]) begin
          valid_q[i] <= 1'b0;
        end else if (wr_hit[i]) begin
          x_q[i]     <= bus.Wr_X;
          y_q[i]     <= bus.Wr_Y;
        end
      end
    end
  end

  // Occupancy follows the actual effects of add and delete.
  always_comb begin
    count_d = count_q + CW'(add_ok) - CW'(del_ok);
  end

  // Occupancy counter and one-cycle add response.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q   <= '0;
      add_ack_q <= 1'b0;
      add_err_q <= 1'b0;
      add_idx_q <= '0;
    end else begin
      count_q   <= count_d;
      add_ack_q <= add_ok;
      add_err_q <= bus.Add && !free_found;
      add_idx_q <= add_ok ? free_idx : '0;
    end
  end

  // Random-read port, straight from the slot flops.
  always_comb begin
    rd_valid = 1'b0;
    rd_x     = '0;
    rd_y     = '0;
    rd_type  = '0;
    if (in_range(bus.Rd_Idx)) begin
      rd_valid = valid_q[bus.Rd_Idx];
      rd_x     = x_q[bus.Rd_Idx];
      rd_y     = y_q[bus.Rd_Idx];
      rd_type  = type_q[bus.Rd_Idx];
    end
  end

  // Scan engine: the first SCAN cycle loads beat 0; afterwards a beat is
  // replaced once it completes (invalid, or valid and accepted). Completion
  // of the last slot's beat ends the scan with a one-cycle Done.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      scan_busy_q <= 1'b0;
      scan_vld_q  <= 1'b0;
      scan_done_q <= 1'b0;
      scan_idx_q  <= '0;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      scan_type_q <= '0;
    end else begin
      scan_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.Scan_Start) begin
            state_q <= S_SCAN;
            ptr_q   <= '0;
          end
        end
        S_SCAN: begin
          if (!scan_busy_q || !scan_vld_q || bus.Scan_Ready) begin
            if (scan_busy_q && (scan_idx_q == LAST_IDX)) begin
              state_q     <= S_DONE;
              scan_busy_q <= 1'b0;
              scan_vld_q  <= 1'b0;
              scan_done_q <= 1'b1;
            end else begin
              scan_busy_q <= 1'b1;
              scan_idx_q  <= ptr_q;
              scan_vld_q  <= valid_q[ptr_q];
              scan_x_q    <= x_q[ptr_q];
              scan_y_q    <= y_q[ptr_q];
              scan_type_q <= type_q[ptr_q];
              ptr_q       <= ptr_q + IW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Add_Ack   = add_ack_q;
  assign bus.Add_Err   = add_err_q;
  assign bus.Add_Idx   = add_idx_q;
  assign bus.Rd_Valid  = rd_valid;
  assign bus.Rd_X      = rd_x;
  assign bus.Rd_Y      = rd_y;
  assign bus.Rd_Type   = rd_type;
  assign bus.Scan_Busy = scan_busy_q;
  assign bus.Scan_Vld  = scan_vld_q;
  assign bus.Scan_Idx  = scan_idx_q;
  assign bus.Scan_X    = scan_x_q;
  assign bus.Scan_Y    = scan_y_q;
  assign bus.Scan_Type = scan_type_q;
  assign bus.Scan_Done = scan_done_q;
  assign bus.Count     = count_q;
  assign bus.Full      = (count_q == FULL_CNT);
  assign bus.Empty     = (count_q == '0);
endmodule
